// File: rtl/rx_rs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rx_rs_pkg
// Brief   : Shared constants and FSM types for the receive RS link-fault path.
// Revision: 1.0 - initial release
// ============================================================================
package rx_rs_pkg;

    localparam logic [7:0] SEQ_CHAR     = 8'h9C;
    localparam logic [7:0] IDLE_CHAR    = 8'h07;
    localparam logic [7:0] FAULT_LOCAL  = 8'h01;
    localparam logic [7:0] FAULT_REMOTE = 8'h02;

    localparam logic [1:0] LF_OK     = 2'b00;
    localparam logic [1:0] LF_LOCAL  = 2'b10;
    localparam logic [1:0] LF_REMOTE = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_FAULT = 2'd2
    } rs_state_e;

    // last_type: 0 = local, 1 = remote
    typedef struct packed {
        rs_state_e  state;
        logic       last_type;
        logic [2:0] seq_cnt;
        logic [7:0] col_cnt;
        logic [1:0] link_fault;
    } rs_ctx_t;

endpackage
`default_nettype wire

// File: rtl/rx_rs_col_decode.sv
`default_nettype none
// ============================================================================
// Module  : rx_rs_col_decode
// Brief   : Decodes one 4-lane XGMII column for fault sequences and scrubs them.
// Revision: 1.0 - initial release
// ============================================================================
module rx_rs_col_decode
    import rx_rs_pkg::*;
(
    input  logic [31:0] i_col_d,
    input  logic [3:0]  i_col_c,
    output logic        o_is_fault,
    output logic        o_fault_type,
    output logic [31:0] o_scrub_d,
    output logic [3:0]  o_scrub_c
);

    logic w_hdr_ok;
    logic w_is_local;
    logic w_is_remote;

    always_comb begin
        w_hdr_ok    = (i_col_c == 4'b0001) && (i_col_d[7:0] == SEQ_CHAR) &&
                      (i_col_d[23:8] == 16'h0000);
        w_is_local  = w_hdr_ok && (i_col_d[31:24] == FAULT_LOCAL);
        w_is_remote = w_hdr_ok && (i_col_d[31:24] == FAULT_REMOTE);

        o_is_fault   = w_is_local || w_is_remote;
        o_fault_type = w_is_remote;
        o_scrub_d    = o_is_fault ? {4{IDLE_CHAR}} : i_col_d;
        o_scrub_c    = o_is_fault ? 4'hF : i_col_c;
    end

endmodule
`default_nettype wire

// File: rtl/rx_rs_link_fault.sv
`default_nettype none
// ============================================================================
// Module  : rx_rs_link_fault
// Brief   : Receive RS stage: link-fault state machine and fault-column scrub.
// Revision: 1.0 - initial release
// ============================================================================
module rx_rs_link_fault
    import rx_rs_pkg::*;
#(
    parameter int COL_WINDOW = 128,
    parameter int SEQ_THRESH = 4
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic [63:0] rxd64_out,
    output logic [7:0]  rxc8_out,
    output logic [1:0]  link_fault,
    output logic        seq_seen
);

    logic [63:0] r_rxd1;
    logic [7:0]  r_rxc1;
    rs_ctx_t     r_ctx;
    rs_ctx_t     w_ctx_a;
    rs_ctx_t     w_ctx_next;

    logic        w_fault_a, w_fault_b;
    logic        w_type_a,  w_type_b;
    logic [31:0] w_scrub_d_a, w_scrub_d_b;
    logic [3:0]  w_scrub_c_a, w_scrub_c_b;

    rx_rs_col_decode u_dec_a (
        .i_col_d      (r_rxd1[31:0]),
        .i_col_c      (r_rxc1[3:0]),
        .o_is_fault   (w_fault_a),
        .o_fault_type (w_type_a),
        .o_scrub_d    (w_scrub_d_a),
        .o_scrub_c    (w_scrub_c_a)
    );

    rx_rs_col_decode u_dec_b (
        .i_col_d      (r_rxd1[63:32]),
        .i_col_c      (r_rxc1[7:4]),
        .o_is_fault   (w_fault_b),
        .o_fault_type (w_type_b),
        .o_scrub_d    (w_scrub_d_b),
        .o_scrub_c    (w_scrub_c_b)
    );

    // One column's worth of state-machine advance; applied to A then to B.
    function automatic rs_ctx_t fsm_step(input rs_ctx_t cur, input logic is_fault,
                                         input logic ftype);
        rs_ctx_t nxt;
        nxt = cur;
        if (is_fault) begin
            nxt.col_cnt = 8'd0;
            if (cur.state == ST_INIT || ftype != cur.last_type) begin
                nxt.state     = ST_COUNT;
                nxt.last_type = ftype;
                nxt.seq_cnt   = 3'd1;
            end else if (cur.state == ST_COUNT) begin
                if (cur.seq_cnt != 3'd7)
                    nxt.seq_cnt = cur.seq_cnt + 3'd1;
                if (int'(nxt.seq_cnt) >= SEQ_THRESH) begin
                    nxt.state      = ST_FAULT;
                    nxt.link_fault = ftype ? LF_REMOTE : LF_LOCAL;
                end
            end
        end else if (cur.state != ST_INIT) begin
            if (cur.col_cnt != 8'hFF)
                nxt.col_cnt = cur.col_cnt + 8'd1;
            if (int'(nxt.col_cnt) >= COL_WINDOW) begin
                nxt.state      = ST_INIT;
                nxt.seq_cnt    = 3'd0;
                nxt.col_cnt    = 8'd0;
                nxt.link_fault = LF_OK;
            end
        end
        return nxt;
    endfunction

    always_comb begin
        w_ctx_a    = fsm_step(r_ctx, w_fault_a, w_type_a);
        w_ctx_next = fsm_step(w_ctx_a, w_fault_b, w_type_b);
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            r_rxd1    <= 64'd0;
            r_rxc1    <= 8'd0;
            r_ctx     <= '0;
            rxd64_out <= 64'd0;
            rxc8_out  <= 8'd0;
            seq_seen  <= 1'b0;
        end else begin
            r_rxd1    <= xgmii_rxd;
            r_rxc1    <= xgmii_rxc;
            r_ctx     <= w_ctx_next;
            rxd64_out <= {w_scrub_d_b, w_scrub_d_a};
            rxc8_out  <= {w_scrub_c_b, w_scrub_c_a};
            seq_seen  <= w_fault_a | w_fault_b;
        end
    end

    assign link_fault = r_ctx.link_fault;

endmodule
`default_nettype wire
